opmem_seq: RTL and testbench
============================

# opmem_seq

Parametrised opcode memory with built-in load and fetch sequencing for the core's instruction path. Replaces the fixed 8-bit × 16 opcode RAM wrapper: the host streams a program in through an auto-incrementing load port, then the block fetches ops in order to the decoder over a valid/ready handshake, with jump support and program-length tracking. It sits between the host/loader and the op decoder.

## Interface
- OP_W, 8, opcode width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- load_start  in  1  enter LOAD, write pointer cleared to 0
- load_valid  in  1  write load_op at the write pointer, pointer +1
- load_op  in  OP_W  opcode to store
- load_end  in  1  close LOAD, latch program length
- run  in  1  start fetching from address 0
- stop  in  1  abort FETCH, return to IDLE
- jump_en  in  1  redirect fetch to jump_addr
- jump_addr  in  ADDR_W  jump target
- op_ready  in  1  decoder accepts the presented op
- op_valid  out  1  op/pc valid
- op  out  OP_W  fetched opcode
- pc  out  ADDR_W  address of the presented op
- prog_len  out  ADDR_W+1  ops in the stored program (0..2**ADDR_W)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at program end
- err  out  1  sticky error flag, cleared only by rst

## Operation
- States: IDLE, LOAD, FETCH. Reset: IDLE, op_valid=0, op=0, pc=0, prog_len=0, done=0, err=0, busy=0. Memory contents are not cleared.
- Priority per cycle: rst > stop > jump_en > load/run/normal sequencing.
- IDLE: load_start -> LOAD. run with prog_len>0 -> FETCH. run with prog_len=0 -> stays IDLE, err=1. load_start and run together: load_start wins.
- LOAD: load_valid writes mem[wptr], wptr+1. After 2**ADDR_W writes -> IDLE automatically, prog_len=2**ADDR_W. load_end -> IDLE, prog_len=wptr including a same-cycle write. load_end with no writes gives prog_len=0. run, jump_en and stop are ignored in LOAD. load_start in LOAD restarts at wptr=0.
- FETCH: synchronous read, one op presented at a time. An op transfers when op_valid && op_ready. While op_valid && !op_ready, op and pc hold stable. After the op at pc = prog_len-1 transfers, see Configuration.
- jump_en in FETCH with jump_addr < prog_len: the presented op is discarded and the next op presented is mem[jump_addr]. jump_addr >= prog_len: jump ignored, err=1. jump_en outside FETCH is ignored.
- stop in FETCH: IDLE next cycle, op_valid=0, no done pulse.
- load_start, load_valid, load_end in FETCH are ignored. A load_valid outside LOAD sets err=1.

## Timing
- run sampled at cycle N: FETCH at N+1, op_valid=1 at N+2 with pc=0, op=mem[0].
- With op_ready held high: one op per cycle, no bubbles.
- jump_en at cycle J: op_valid=0 at J+1, mem[jump_addr] presented at J+2.
- A write at cycle W is readable by a fetch issued at W+1 or later.
- done is asserted for exactly the cycle after the final transfer. op_valid=0 in that cycle when not looping.
- rst mid-FETCH or mid-LOAD: all outputs take reset values next cycle. A partial load leaves prog_len=0.

## Configuration
- OPMEM_LOOP_EN defined: after the op at prog_len-1 transfers, fetch wraps to address 0 with no bubble. done pulses once per wrap. FETCH persists until stop or rst.
- Not defined: after the final transfer the block goes to IDLE. done pulses and op_valid drops.

## Test plan
- Load 5 ops 0x11..0x15, load_end, run, op_ready=1 -> prog_len=5, ops 0x11..0x15 with pc 0..4 on consecutive cycles starting 2 cycles after run. Then done=1 and IDLE (no loop), or 0x11 at pc=0 next (loop).
- Stall: op_ready=0 for 3 cycles while pc=2 is presented -> op=0x13 and pc=2 stable throughout, then the sequence resumes at pc=3.
- Fill: 16 load_valid writes with default params -> auto IDLE, prog_len=16. A 17th load_valid -> err=1, memory unchanged.
- Jump: jump_en with jump_addr=1 while pc=3 is presented -> one bubble, then op=0x12 at pc=1. jump_addr=7 with prog_len=5 -> ignored, err=1.
- Errors and reset: run with prog_len=0 -> err=1, stays IDLE. rst during FETCH -> next cycle op_valid=0, pc=0, prog_len=0, err=0, busy=0.

Source files
------------

// File: rtl/opmem_seq.sv
// Opcode memory with auto-incrementing program load and in-order valid/ready fetch.
// Optional feature macro: OPMEM_LOOP_EN (fetch wraps to address 0 instead of ending).
module opmem_seq #(
  parameter int OP_W   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [OP_W-1:0]   load_op,
  input  logic              load_end,
  input  logic              run,
  input  logic              stop,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              op_ready,
  output logic              op_valid,
  output logic [OP_W-1:0]   op,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FETCH} state_t;

  state_t            state;
  logic [OP_W-1:0]   mem [DEPTH];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W-1:0] fptr;
  logic              wr_en;
  logic              last_xfer;
  logic              jump_ok;

  // load_start in LOAD restarts the pointer, so a coincident write is dropped
  assign wr_en     = !rst && (state == S_LOAD) && load_valid && !load_start;
  assign last_xfer = op_valid && op_ready &&
                     ({1'b0, pc} == prog_len - (ADDR_W+1)'(1));
  assign jump_ok   = ({1'b0, jump_addr} < prog_len);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[ADDR_W-1:0]] <= load_op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wptr     <= '0;
      fptr     <= '0;
      op_valid <= 1'b0;
      op       <= '0;
      pc       <= '0;
      prog_len <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load_valid && state != S_LOAD) err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (load_start) begin
            state    <= S_LOAD;
            wptr     <= '0;
            prog_len <= '0;
          end else if (run) begin
            if (prog_len != '0) begin
              state    <= S_FETCH;
              fptr     <= '0;
              op_valid <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (load_start) begin
            wptr <= '0;
          end else begin
            if (load_valid) begin
              wptr <= wptr + 1'b1;
              if (wptr == (ADDR_W+1)'(DEPTH - 1)) begin
                state    <= S_IDLE;
                prog_len <= (ADDR_W+1)'(DEPTH);
              end
            end
            if (load_end) begin
              state    <= S_IDLE;
              prog_len <= load_valid ? wptr + 1'b1 : wptr;
            end
          end
        end
        S_FETCH: begin
          if (stop) begin
            state    <= S_IDLE;
            op_valid <= 1'b0;
          end else if (jump_en && jump_ok) begin
            // Presented op is dropped; the target is read on the next cycle
            op_valid <= 1'b0;
            fptr     <= jump_addr;
          end else begin
            if (jump_en) err <= 1'b1;
            if (last_xfer) begin
              done <= 1'b1;
`ifdef OPMEM_LOOP_EN
              op       <= mem[0];
              pc       <= '0;
              fptr     <= ADDR_W'(1);
              op_valid <= 1'b1;
`else
              state    <= S_IDLE;
              op_valid <= 1'b0;
`endif
            end else if (!op_valid || op_ready) begin
              op       <= mem[fptr];
              pc       <= fptr;
              fptr     <= fptr + 1'b1;
              op_valid <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opmem_seq.sv
// Scoreboard bench for opmem_seq: expected (pc, op) pairs are queued when a run
// is started and popped as each op is presented by the DUT.
module tb_opmem_seq;

  logic       clk = 1'b0;
  logic       rst, load_start, load_valid, load_end, run, stop, jump_en, op_ready;
  logic [7:0] load_op, op;
  logic [3:0] jump_addr, pc;
  logic [4:0] prog_len;
  logic       op_valid, busy, done, err;

  typedef struct {
    logic [3:0] pc;
    logic [7:0] op;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] model_mem [16];
  int         n_tests = 0;
  int         n_fail  = 0;

  opmem_seq #(.OP_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_op(load_op), .load_end(load_end), .run(run), .stop(stop),
    .jump_en(jump_en), .jump_addr(jump_addr), .op_ready(op_ready),
    .op_valid(op_valid), .op(op), .pc(pc), .prog_len(prog_len),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog(input int n, input logic [7:0] base);
    load_start = 1'b1; tick; load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_op = base + 8'(i);
      model_mem[i] = load_op;
      tick;
    end
    load_valid = 1'b0;
    load_end = 1'b1; tick; load_end = 1'b0;
  endtask

  task automatic push_range(input int lo, input int hi);
    exp_t e;
    for (int i = lo; i <= hi; i++) begin
      e.pc = 4'(i);
      e.op = model_mem[i];
      sbq.push_back(e);
    end
  endtask

  task automatic start_run;
    run = 1'b1; tick; run = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; tick; tick; rst = 1'b0;
    n_tests++;
    if ({op_valid, busy, done, err, pc, op, prog_len} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset: got valid=%0b busy=%0b done=%0b err=%0b pc=%0d op=%02h len=%0d, expected all 0",
               op_valid, busy, done, err, pc, op, prog_len);
    end
  endtask

  task automatic test_run_empty;
    start_run;
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0 || op_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL run_empty: got err=%0b busy=%0b valid=%0b, expected err=1 busy=0 valid=0", err, busy, op_valid);
    end
    rst = 1'b1; tick; rst = 1'b0;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got err=%0b, expected 0", err);
    end
  endtask

  task automatic test_basic;
    exp_t e;
    load_prog(5, 8'h11);
    n_tests++;
    if (prog_len !== 5'd5 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_len: got len=%0d busy=%0b, expected len=5 busy=0", prog_len, busy);
    end
    push_range(0, 4);
    op_ready = 1'b1;
    start_run;
    n_tests++;
    if (op_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL run_latency: got valid=%0b busy=%0b, expected valid=0 busy=1", op_valid, busy);
    end
    tick;
    for (int c = 0; c < 5; c++) begin
      e = sbq.pop_front();
      n_tests++;
      if (op_valid !== 1'b1 || pc !== e.pc || op !== e.op) begin
        n_fail++;
        $display("FAIL basic_fetch[%0d]: got valid=%0b pc=%0d op=%02h, expected valid=1 pc=%0d op=%02h",
                 c, op_valid, pc, op, e.pc, e.op);
      end
      tick;
    end
`ifdef OPMEM_LOOP_EN
    n_tests++;
    if (done !== 1'b1 || op_valid !== 1'b1 || pc !== 4'd0 || op !== 8'h11) begin
      n_fail++;
      $display("FAIL basic_wrap: got done=%0b valid=%0b pc=%0d op=%02h, expected done=1 valid=1 pc=0 op=11",
               done, op_valid, pc, op);
    end
    stop = 1'b1; tick; stop = 1'b0;
`else
    n_tests++;
    if (done !== 1'b1 || op_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: got done=%0b valid=%0b busy=%0b, expected done=1 valid=0 busy=0",
               done, op_valid, busy);
    end
    tick;
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%0b, expected 0", done);
    end
`endif
  endtask

  task automatic test_stall;
    exp_t e;
    push_range(0, 4);
    op_ready = 1'b1;
    start_run;
    tick;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick;
      e = sbq.pop_front();
      n_tests++;
      if (op_valid !== 1'b1 || pc !== e.pc || op !== e.op) begin
        n_fail++;
        $display("FAIL stall_pre[%0d]: got valid=%0b pc=%0d op=%02h, expected valid=1 pc=%0d op=%02h",
                 c, op_valid, pc, op, e.pc, e.op);
      end
    end
    op_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick;
      n_tests++;
      if (op_valid !== 1'b1 || pc !== 4'd2 || op !== 8'h13) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%0b pc=%0d op=%02h, expected valid=1 pc=2 op=13",
                 s, op_valid, pc, op);
      end
    end
    op_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick;
      e = sbq.pop_front();
      n_tests++;
      if (op_valid !== 1'b1 || pc !== e.pc || op !== e.op) begin
        n_fail++;
        $display("FAIL stall_post[%0d]: got valid=%0b pc=%0d op=%02h, expected valid=1 pc=%0d op=%02h",
                 c, op_valid, pc, op, e.pc, e.op);
      end
    end
    tick;
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_done: got done=%0b, expected 1", done);
    end
    stop = 1'b1; tick; stop = 1'b0;
  endtask

  task automatic test_jump;
    exp_t e;
    push_range(0, 3);
    push_range(1, 4);
    op_ready = 1'b1;
    start_run;
    tick;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick;
      e = sbq.pop_front();
      n_tests++;
      if (op_valid !== 1'b1 || pc !== e.pc || op !== e.op) begin
        n_fail++;
        $display("FAIL jump_pre[%0d]: got valid=%0b pc=%0d op=%02h, expected valid=1 pc=%0d op=%02h",
                 c, op_valid, pc, op, e.pc, e.op);
      end
    end
    jump_en = 1'b1; jump_addr = 4'd1;
    tick;
    jump_en = 1'b0;
    n_tests++;
    if (op_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_bubble: got valid=%0b, expected 0", op_valid);
    end
    tick;
    for (int c = 0; c < 4; c++) begin
      e = sbq.pop_front();
      n_tests++;
      if (op_valid !== 1'b1 || pc !== e.pc || op !== e.op) begin
        n_fail++;
        $display("FAIL jump_post[%0d]: got valid=%0b pc=%0d op=%02h, expected valid=1 pc=%0d op=%02h",
                 c, op_valid, pc, op, e.pc, e.op);
      end
      tick;
    end
    n_tests++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_done: got done=%0b err=%0b, expected done=1 err=0", done, err);
    end
    stop = 1'b1; tick; stop = 1'b0;
  endtask

  task automatic test_bad_jump;
    exp_t e;
    push_range(0, 4);
    op_ready = 1'b1;
    start_run;
    tick;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        n_tests++;
        if (err !== 1'b1) begin
          n_fail++;
          $display("FAIL bad_jump_err: got err=%0b, expected 1", err);
        end
      end
      e = sbq.pop_front();
      n_tests++;
      if (op_valid !== 1'b1 || pc !== e.pc || op !== e.op) begin
        n_fail++;
        $display("FAIL bad_jump_seq[%0d]: got valid=%0b pc=%0d op=%02h, expected valid=1 pc=%0d op=%02h",
                 c, op_valid, pc, op, e.pc, e.op);
      end
      jump_en = (c == 0);
      jump_addr = 4'd7;
      tick;
    end
    jump_en = 1'b0;
    n_tests++;
    if (done !== 1'b1 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_jump_end: got done=%0b err=%0b, expected done=1 err=1", done, err);
    end
    stop = 1'b1; tick; stop = 1'b0;
    rst = 1'b1; tick; rst = 1'b0;
  endtask

  task automatic test_fill;
    exp_t e;
    load_start = 1'b1; tick; load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1;
      load_op = 8'hA0 + 8'(i);
      model_mem[i] = load_op;
      tick;
    end
    load_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || prog_len !== 5'd16 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_auto: got busy=%0b len=%0d err=%0b, expected busy=0 len=16 err=0", busy, prog_len, err);
    end
    load_valid = 1'b1; load_op = 8'hFF; tick; load_valid = 1'b0;
    n_tests++;
    if (err !== 1'b1 || prog_len !== 5'd16) begin
      n_fail++;
      $display("FAIL fill_extra: got err=%0b len=%0d, expected err=1 len=16", err, prog_len);
    end
    push_range(0, 15);
    op_ready = 1'b1;
    start_run;
    tick;
    for (int c = 0; c < 16; c++) begin
      e = sbq.pop_front();
      n_tests++;
      if (op_valid !== 1'b1 || pc !== e.pc || op !== e.op) begin
        n_fail++;
        $display("FAIL fill_fetch[%0d]: got valid=%0b pc=%0d op=%02h, expected valid=1 pc=%0d op=%02h",
                 c, op_valid, pc, op, e.pc, e.op);
      end
      tick;
    end
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_done: got done=%0b, expected 1", done);
    end
    stop = 1'b1; tick; stop = 1'b0;
    rst = 1'b1; tick; rst = 1'b0;
  endtask

  task automatic test_load_edge;
    exp_t e;
    load_start = 1'b1; tick; load_start = 1'b0;
    load_end = 1'b1; tick; load_end = 1'b0;
    n_tests++;
    if (prog_len !== 5'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_load: got len=%0d busy=%0b, expected len=0 busy=0", prog_len, busy);
    end
    load_start = 1'b1; tick; load_start = 1'b0;
    load_valid = 1'b1; load_op = 8'h31; model_mem[0] = 8'h31; tick;
    load_op = 8'h32; model_mem[1] = 8'h32; load_end = 1'b1; tick;
    load_valid = 1'b0; load_end = 1'b0;
    n_tests++;
    if (prog_len !== 5'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL end_with_write: got len=%0d busy=%0b, expected len=2 busy=0", prog_len, busy);
    end
    push_range(0, 0);
    op_ready = 1'b1;
    start_run;
    tick;
    e = sbq.pop_front();
    n_tests++;
    if (op_valid !== 1'b1 || pc !== e.pc || op !== e.op) begin
      n_fail++;
      $display("FAIL edge_fetch: got valid=%0b pc=%0d op=%02h, expected valid=1 pc=%0d op=%02h",
               op_valid, pc, op, e.pc, e.op);
    end
    stop = 1'b1; tick; stop = 1'b0;
    n_tests++;
    if (op_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL stop: got valid=%0b busy=%0b done=%0b, expected all 0", op_valid, busy, done);
    end
  endtask

  task automatic test_rst_fetch;
    op_ready = 1'b1;
    start_run;
    tick; tick;
    rst = 1'b1; tick; rst = 1'b0;
    n_tests++;
    if ({op_valid, busy, done, err, pc, op, prog_len} !== 21'd0) begin
      n_fail++;
      $display("FAIL rst_fetch: got valid=%0b busy=%0b done=%0b err=%0b pc=%0d op=%02h len=%0d, expected all 0",
               op_valid, busy, done, err, pc, op, prog_len);
    end
    load_start = 1'b1; tick; load_start = 1'b0;
    load_valid = 1'b1; load_op = 8'h55; tick; tick; load_valid = 1'b0;
    rst = 1'b1; tick; rst = 1'b0;
    n_tests++;
    if (prog_len !== 5'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_load: got len=%0d busy=%0b, expected len=0 busy=0", prog_len, busy);
    end
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_end = 1'b0; load_op = '0;
    run = 1'b0; stop = 1'b0; jump_en = 1'b0; jump_addr = '0; op_ready = 1'b0;
    test_reset;
    test_run_empty;
    test_basic;
    test_stall;
    test_jump;
    test_bad_jump;
    test_fill;
    test_load_edge;
    test_rst_fetch;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
